// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Optional statistics outputs on dmem_arbiter are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    // owner      | meaning
    // OWN_NONE   | memory idle (or in reset) last cycle
    // OWN_PIPE   | MEM stage used the port last cycle
    // OWN_DBG    | debug/loader used the port last cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam int DEFAULT_STARVE_MAX = 8;
    localparam int DEFAULT_CNT_W      = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive refused debug cycles; at_max forces the next debug grant.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX = DEFAULT_STARVE_MAX,
    parameter int W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] count;

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (priority) and a debug requester.
// Define DMEM_ARB_STATS_EN to add wrapping grant/stall statistics outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    input  logic        dbg_valid,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wen,
    input  logic [31:0] ram_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_pipe_cnt,
    output logic [31:0] stat_dbg_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);

    logic   at_max;
    logic   dbg_grant;
    logic   pipe_grant;
    logic   dbg_rd_q;
    owner_t owner;

    // Reset gates both grants so no write or handshake can escape while rst is high.
    assign dbg_grant  = !rst && dbg_valid && (!mem_req || at_max);
    assign pipe_grant = !rst && mem_req && !dbg_grant;

    assign ram_addr  = dbg_grant ? dbg_addr  : mem_addr;
    assign ram_wdata = dbg_grant ? dbg_wdata : mem_wdata;
    assign ram_wen   = dbg_grant ? dbg_we    : (pipe_grant && mem_we);
    assign mem_stall = dbg_grant && mem_req;
    assign dbg_ready = dbg_grant;
    assign mem_rdata = ram_rdata;

    dmem_arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .clear  (dbg_grant || !dbg_valid),
        .inc    (dbg_valid && !dbg_grant),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_NONE;
            dbg_rd_q  <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            if (dbg_grant) begin
                owner <= OWN_DBG;
            end else if (pipe_grant) begin
                owner <= OWN_PIPE;
            end else begin
                owner <= OWN_NONE;
            end
            dbg_rd_q <= dbg_grant && !dbg_we;
            if (dbg_grant && !dbg_we) begin
                dbg_rdata <= ram_rdata;
            end
        end
    end

    // Both terms are registered, so the pulse is clean and lands one cycle after dbg_ready.
    assign dbg_rvalid = (owner == OWN_DBG) && dbg_rd_q;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pipe_cnt  <= '0;
            stat_dbg_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (pipe_grant) stat_pipe_cnt  <= stat_pipe_cnt + 32'd1;
            if (dbg_grant)  stat_dbg_cnt   <= stat_dbg_cnt + 32'd1;
            if (mem_stall)  stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus hand sequences for starvation, collision and reset corners.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall;
    logic        dbg_valid, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wen;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_pipe_cnt, stat_dbg_cnt, stat_stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) ram[ram_addr[7:0]] <= ram_wdata;
    end
    assign ram_rdata = ram[ram_addr[7:0]];

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .dbg_valid  (dbg_valid),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wen    (ram_wen),
        .ram_rdata  (ram_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_pipe_cnt  (stat_pipe_cnt),
        .stat_dbg_cnt   (stat_dbg_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        dv;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_wen;
        logic        e_stall;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic mreq, input logic mwe, input logic [31:0] maddr,
                         input logic [31:0] mwd, input logic dv, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        mem_req   = mreq;
        mem_we    = mwe;
        mem_addr  = maddr;
        mem_wdata = mwd;
        dbg_valid = dv;
        dbg_we    = dwe;
        dbg_addr  = daddr;
        dbg_wdata = dwd;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h44, 32'h11, 1'b0, 1'b0, 32'h0,  32'h0,  32'h44, 32'h11, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h48, 32'h22, 1'b0, 1'b0, 32'h0,  32'h0,  32'h48, 32'h22, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h30, 32'hA5, 1'b0, 1'b0, 32'h0,  32'h0,  32'h30, 32'hA5, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h34, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  32'h34, 32'h0,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h50, 32'h1,  1'b1, 1'b1, 32'h40, 32'h77, 32'h40, 32'h77, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h50, 32'h1,  1'b1, 1'b0, 32'h44, 32'h9,  32'h44, 32'h9,  1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h60, 32'h66, 1'b1, 1'b1, 32'h64, 32'h99, 32'h60, 32'h66, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h68, 32'h3,  1'b1, 1'b0, 32'h6C, 32'h4,  32'h68, 32'h3,  1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'h70, 32'h5,  1'b0, 1'b0, 32'h0,  32'h0,  32'h70, 32'h5,  1'b0, 1'b0, 1'b0};

        // Reset with every request active: outputs must stay quiet.
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 32'h14, 32'h2);
        to_drive();
        to_sample();
        chk("rst_wen",    {31'b0, ram_wen},    32'd0);
        chk("rst_ready",  {31'b0, dbg_ready},  32'd0);
        chk("rst_stall",  {31'b0, mem_stall},  32'd0);
        chk("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rst_rdata",  dbg_rdata,           32'd0);
        to_drive();
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].mreq, vecs[i].mwe, vecs[i].maddr, vecs[i].mwd,
                  vecs[i].dv, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            to_sample();
            chk($sformatf("v%0d_addr", i),  ram_addr,               vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), ram_wdata,              vecs[i].e_wd);
            chk($sformatf("v%0d_wen", i),   {31'b0, ram_wen},       {31'b0, vecs[i].e_wen});
            chk($sformatf("v%0d_stall", i), {31'b0, mem_stall},     {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_ready", i), {31'b0, dbg_ready},     {31'b0, vecs[i].e_rdy});
            to_drive();
        end

        // Pipeline store then load.
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        to_sample();
        chk("pst_wen",   {31'b0, ram_wen},   32'd1);
        chk("pst_stall", {31'b0, mem_stall}, 32'd0);
        to_drive();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_sample();
        chk("pld_rdata", mem_rdata,          32'hDEADBEEF);
        chk("pld_stall", {31'b0, mem_stall}, 32'd0);
        to_drive();

        // Debug read while the pipeline is idle.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        to_sample();
        chk("drd_ready",  {31'b0, dbg_ready},  32'd1);
        chk("drd_rvalid0",{31'b0, dbg_rvalid}, 32'd0);
        to_drive();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_sample();
        chk("drd_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        chk("drd_rdata",  dbg_rdata,           32'hDEADBEEF);
        to_drive();
        to_sample();
        chk("drd_rvalid_end", {31'b0, dbg_rvalid}, 32'd0);
        chk("drd_rdata_hold", dbg_rdata,           32'hDEADBEEF);
        to_drive();

        // Starvation: 8 refusals, forced on the 9th, then the counter restarts from 0.
        for (int round = 0; round < 2; round++) begin
            drive(1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
            for (int i = 1; i <= 8; i++) begin
                to_sample();
                chk($sformatf("stv%0d_ref%0d_ready", round, i), {31'b0, dbg_ready}, 32'd0);
                chk($sformatf("stv%0d_ref%0d_stall", round, i), {31'b0, mem_stall}, 32'd0);
                if (i == 1)
                    chk($sformatf("stv%0d_rvalid", round), {31'b0, dbg_rvalid}, {31'b0, round == 1});
                to_drive();
            end
            to_sample();
            chk($sformatf("stv%0d_force_ready", round), {31'b0, dbg_ready}, 32'd1);
            chk($sformatf("stv%0d_force_stall", round), {31'b0, mem_stall}, 32'd1);
            chk($sformatf("stv%0d_force_addr", round),  ram_addr,           32'h10);
            to_drive();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_drive();

        // Collision: forced debug write to 0x20 displaces a pipeline load of 0x20.
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);
        for (int i = 0; i < 8; i++) to_drive();
        to_sample();
        chk("col_stall", {31'b0, mem_stall}, 32'd1);
        chk("col_wen",   {31'b0, ram_wen},   32'd1);
        chk("col_wdata", ram_wdata,          32'h55);
        to_drive();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_sample();
        chk("col_stall_after", {31'b0, mem_stall}, 32'd0);
        chk("col_rdata",       mem_rdata,          32'h55);
        to_drive();

        // Reset after 4 refusals; afterwards a full 8 refusals are needed again.
        drive(1'b1, 1'b1, 32'h74, 32'h1, 1'b1, 1'b1, 32'h78, 32'hBAD);
        for (int i = 0; i < 4; i++) to_drive();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            to_sample();
            chk("mid_rst_wen",    {31'b0, ram_wen},    32'd0);
            chk("mid_rst_ready",  {31'b0, dbg_ready},  32'd0);
            chk("mid_rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
            chk("mid_rst_stall",  {31'b0, mem_stall},  32'd0);
            to_drive();
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            to_sample();
            chk($sformatf("post_rst_ref%0d", i), {31'b0, dbg_ready}, 32'd0);
            to_drive();
        end
        to_sample();
        chk("post_rst_force", {31'b0, dbg_ready}, 32'd1);
        to_drive();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_drive();

`ifdef DMEM_ARB_STATS_EN
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h80, 32'h1, 1'b1, 1'b0, 32'h84, 32'h0);
        for (int i = 0; i < 9; i++) to_drive();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) to_drive();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        to_sample();
        chk("stat_pipe",  stat_pipe_cnt,  32'd10);
        chk("stat_dbg",   stat_dbg_cnt,   32'd1);
        chk("stat_stall", stat_stall_cnt, 32'd1);
        to_drive();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
